// File: rtl/dac_output_conditioner.sv
// Two-channel DAC sample conditioner: offset, saturate, window clamp,
// slew limit and mute ramp, configured over the cmd bus.
module dac_output_conditioner #(
  parameter logic [7:0]  WR_PAGE  = 8'h22,
  parameter logic [7:0]  RD_PAGE  = 8'h23,
  parameter logic [15:0] SLEW_RST = 16'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_trig_in,
  input  logic [15:0] cmd_addr_in,
  input  logic [15:0] cmd_data_in,
  output logic [15:0] cmd_data_out,
  input  logic        valid_in,
  input  logic [15:0] data0_in,
  input  logic [15:0] data1_in,
  output logic        valid_out,
  output logic [15:0] DAC0_out,
  output logic [15:0] DAC1_out,
  output logic [1:0]  sat_out
);

  localparam logic [7:0] R_OFS0   = 8'h00;
  localparam logic [7:0] R_OFS1   = 8'h01;
  localparam logic [7:0] R_MAX0   = 8'h02;
  localparam logic [7:0] R_MIN0   = 8'h03;
  localparam logic [7:0] R_MAX1   = 8'h04;
  localparam logic [7:0] R_MIN1   = 8'h05;
  localparam logic [7:0] R_SLEW   = 8'h06;
  localparam logic [7:0] R_CTRL   = 8'h07;
  localparam logic [7:0] R_STATUS = 8'h08;

  logic [15:0] ofs0_q, ofs0_d;
  logic [15:0] ofs1_q, ofs1_d;
  logic [15:0] max0_q, max0_d;
  logic [15:0] min0_q, min0_d;
  logic [15:0] max1_q, max1_d;
  logic [15:0] min1_q, min1_d;
  logic [15:0] slew_q, slew_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [1:0]  sat_q, sat_d;
  logic [15:0] rdat_q, rdat_d;

  logic        v1_q, v2_q, v3_q;
  logic [15:0] s1_0_q, s1_0_d;
  logic [15:0] s1_1_q, s1_1_d;
  logic [15:0] t2_0_q, t2_0_d;
  logic [15:0] t2_1_q, t2_1_d;
  logic [15:0] cur0_q, cur0_d;
  logic [15:0] cur1_q, cur1_d;

  logic        wr_en, rd_en, stat_clr;
  logic [7:0]  idx;
  logic [15:0] rd_mux;
  logic        s1_sat0, s1_sat1;
  logic        s2_chg0, s2_chg1;

  // Offset add with 17-bit headroom, then saturate back to 16 bits.
  function automatic logic [16:0] add_sat(input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] sum;
    logic [15:0] res;
    logic        ovf;
    sum = {a[15], a} + {b[15], b};
    ovf = sum[16] ^ sum[15];
    res = sum[15:0];
    if (ovf) res = sum[16] ? 16'h8000 : 16'h7fff;
    return {ovf, res};
  endfunction

  // Window clamp; when MIN > MAX the upper bound wins.
  function automatic logic [15:0] clamp(input logic [15:0] x,
                                        input logic [15:0] lo,
                                        input logic [15:0] hi);
    logic [15:0] r;
    r = ($signed(x) < $signed(lo)) ? lo : x;
    if ($signed(r) > $signed(hi)) r = hi;
    return r;
  endfunction

  function automatic logic [15:0] slew_step(input logic [15:0] cur,
                                            input logic [15:0] tgt,
                                            input logic [15:0] slew);
    logic [17:0] diff;
    logic [17:0] mag;
    logic [17:0] nxt;
    diff = {{2{tgt[15]}}, tgt} - {{2{cur[15]}}, cur};
    mag  = diff[17] ? (18'd0 - diff) : diff;
    if (slew == 16'h0 || mag <= {2'b00, slew}) begin
      nxt = {{2{tgt[15]}}, tgt};
    end else if (diff[17]) begin
      nxt = {{2{cur[15]}}, cur} - {2'b00, slew};
    end else begin
      nxt = {{2{cur[15]}}, cur} + {2'b00, slew};
    end
    return nxt[15:0];
  endfunction

  assign idx      = cmd_addr_in[7:0];
  assign wr_en    = cmd_trig_in && (cmd_addr_in[15:8] == WR_PAGE);
  assign rd_en    = cmd_trig_in && (cmd_addr_in[15:8] == RD_PAGE);
  assign stat_clr = wr_en && (idx == R_STATUS);

  always_comb begin
    ofs0_d = ofs0_q;
    ofs1_d = ofs1_q;
    max0_d = max0_q;
    min0_d = min0_q;
    max1_d = max1_q;
    min1_d = min1_q;
    slew_d = slew_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      case (idx)
        R_OFS0:  ofs0_d = cmd_data_in;
        R_OFS1:  ofs1_d = cmd_data_in;
        R_MAX0:  max0_d = cmd_data_in;
        R_MIN0:  min0_d = cmd_data_in;
        R_MAX1:  max1_d = cmd_data_in;
        R_MIN1:  min1_d = cmd_data_in;
        R_SLEW:  slew_d = cmd_data_in;
        R_CTRL:  ctrl_d = cmd_data_in[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 16'h0;
    case (idx)
      R_OFS0:   rd_mux = ofs0_q;
      R_OFS1:   rd_mux = ofs1_q;
      R_MAX0:   rd_mux = max0_q;
      R_MIN0:   rd_mux = min0_q;
      R_MAX1:   rd_mux = max1_q;
      R_MIN1:   rd_mux = min1_q;
      R_SLEW:   rd_mux = slew_q;
      R_CTRL:   rd_mux = {14'h0, ctrl_q};
      R_STATUS: rd_mux = {14'h0, sat_q};
      default:  rd_mux = 16'h0;
    endcase
    rdat_d = rd_en ? rd_mux : rdat_q;
  end

  always_comb begin
    s1_0_d  = s1_0_q;
    s1_1_d  = s1_1_q;
    s1_sat0 = 1'b0;
    s1_sat1 = 1'b0;
    if (valid_in) begin
      {s1_sat0, s1_0_d} = add_sat(data0_in, ofs0_q);
      {s1_sat1, s1_1_d} = add_sat(data1_in, ofs1_q);
    end
  end

  always_comb begin
    t2_0_d  = t2_0_q;
    t2_1_d  = t2_1_q;
    s2_chg0 = 1'b0;
    s2_chg1 = 1'b0;
    if (v1_q) begin
      t2_0_d = ctrl_q[0] ? 16'h0 : clamp(s1_0_q, min0_q, max0_q);
      t2_1_d = ctrl_q[1] ? 16'h0 : clamp(s1_1_q, min1_q, max1_q);
      s2_chg0 = !ctrl_q[0] && (t2_0_d != s1_0_q);
      s2_chg1 = !ctrl_q[1] && (t2_1_d != s1_1_q);
    end
  end

  always_comb begin
    cur0_d = cur0_q;
    cur1_d = cur1_q;
    if (v2_q) begin
      cur0_d = slew_step(cur0_q, t2_0_q, slew_q);
      cur1_d = slew_step(cur1_q, t2_1_q, slew_q);
    end
  end

  // Clear first so a coincident set survives.
  always_comb begin
    sat_d = stat_clr ? 2'b00 : sat_q;
    sat_d = sat_d | {s1_sat1 | s2_chg1, s1_sat0 | s2_chg0};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ofs0_q <= 16'h0;
      ofs1_q <= 16'h0;
      max0_q <= 16'h7fff;
      min0_q <= 16'h8000;
      max1_q <= 16'h7fff;
      min1_q <= 16'h8000;
      slew_q <= SLEW_RST;
      ctrl_q <= 2'b00;
      sat_q  <= 2'b00;
      rdat_q <= 16'h0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_0_q <= 16'h0;
      s1_1_q <= 16'h0;
      t2_0_q <= 16'h0;
      t2_1_q <= 16'h0;
      cur0_q <= 16'h0;
      cur1_q <= 16'h0;
    end else begin
      ofs0_q <= ofs0_d;
      ofs1_q <= ofs1_d;
      max0_q <= max0_d;
      min0_q <= min0_d;
      max1_q <= max1_d;
      min1_q <= min1_d;
      slew_q <= slew_d;
      ctrl_q <= ctrl_d;
      sat_q  <= sat_d;
      rdat_q <= rdat_d;
      v1_q   <= valid_in;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      s1_0_q <= s1_0_d;
      s1_1_q <= s1_1_d;
      t2_0_q <= t2_0_d;
      t2_1_q <= t2_1_d;
      cur0_q <= cur0_d;
      cur1_q <= cur1_d;
    end
  end

  assign cmd_data_out = rdat_q;
  assign valid_out    = v3_q;
  assign DAC0_out     = cur0_q;
  assign DAC1_out     = cur1_q;
  assign sat_out      = sat_q;

endmodule

// File: tb/tb_dac_output_conditioner.sv
// Scoreboard bench for dac_output_conditioner with an integer
// reference model of offset/saturate/clamp/slew/mute.
module tb_dac_output_conditioner;

  logic        clk_in = 0;
  logic        rst_in;
  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in;
  logic [15:0] cmd_data_in;
  logic [15:0] cmd_data_out;
  logic        valid_in;
  logic [15:0] data0_in;
  logic [15:0] data1_in;
  logic        valid_out;
  logic [15:0] DAC0_out;
  logic [15:0] DAC1_out;
  logic [1:0]  sat_out;

  dac_output_conditioner dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cmd_trig_in(cmd_trig_in), .cmd_addr_in(cmd_addr_in),
    .cmd_data_in(cmd_data_in), .cmd_data_out(cmd_data_out),
    .valid_in(valid_in), .data0_in(data0_in), .data1_in(data1_in),
    .valid_out(valid_out), .DAC0_out(DAC0_out), .DAC1_out(DAC1_out),
    .sat_out(sat_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rm [0:7];
  logic [1:0]  msat;
  int          mcur [0:1];
  logic [31:0] expq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    rm[0] = 16'h0; rm[1] = 16'h0;
    rm[2] = 16'h7fff; rm[3] = 16'h8000;
    rm[4] = 16'h7fff; rm[5] = 16'h8000;
    rm[6] = 16'h0; rm[7] = 16'h0;
    msat = 2'b00;
    mcur[0] = 0; mcur[1] = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] i);
    if (i == 8'h07) return {14'h0, rm[7][1:0]};
    if (i < 8'h07) return rm[i[2:0]];
    if (i == 8'h08) return {14'h0, msat};
    return 16'h0;
  endfunction

  task automatic model_write(input logic [7:0] i, input logic [15:0] d);
    if (i == 8'h07) rm[7] = {14'h0, d[1:0]};
    else if (i < 8'h07) rm[i[2:0]] = d;
    else if (i == 8'h08) msat = 2'b00;
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_sample(input logic [15:0] x0, input logic [15:0] x1);
    logic [15:0] xs [0:1];
    logic [15:0] o [0:1];
    int s, t, lo, hi, diff, sl;
    xs[0] = x0; xs[1] = x1;
    sl = int'(rm[6]);
    for (int c = 0; c < 2; c++) begin
      s = sx(xs[c]) + sx(rm[c]);
      if (s > 32767) begin s = 32767; msat[c] = 1'b1; end
      if (s < -32768) begin s = -32768; msat[c] = 1'b1; end
      if (rm[7][c]) begin
        t = 0;
      end else begin
        lo = sx(rm[3 + 2 * c]);
        hi = sx(rm[2 + 2 * c]);
        t = (s < lo) ? lo : s;
        if (t > hi) t = hi;
        if (t != s) msat[c] = 1'b1;
      end
      diff = t - mcur[c];
      if (sl == 0 || (diff < 0 ? -diff : diff) <= sl) mcur[c] = t;
      else if (diff > 0) mcur[c] = mcur[c] + sl;
      else mcur[c] = mcur[c] - sl;
      o[c] = mcur[c][15:0];
    end
    expq.push_back({o[0], o[1]});
  endtask

  task automatic step(input logic trig, input logic [15:0] a,
                      input logic [15:0] d, input logic v,
                      input logic [15:0] x0, input logic [15:0] x1);
    cmd_trig_in = trig; cmd_addr_in = a; cmd_data_in = d;
    valid_in = v; data0_in = x0; data1_in = x1;
    if (v) model_sample(x0, x1);
    if (trig && a[15:8] == 8'h22) model_write(a[7:0], d);
    @(posedge clk_in); #1;
    cmd_trig_in = 1'b0; valid_in = 1'b0;
  endtask

  task automatic wr(input logic [7:0] i, input logic [15:0] d);
    step(1'b1, {8'h22, i}, d, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rd(input logic [7:0] i, input string nm);
    step(1'b1, {8'h23, i}, 16'h0, 1'b0, 16'h0, 16'h0);
    chk(nm, {16'h0, cmd_data_out}, {16'h0, model_read(i)});
  endtask

  task automatic smp(input logic [15:0] x0, input logic [15:0] x1);
    step(1'b0, 16'h0, 16'h0, 1'b1, x0, x1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    idle(5);
    chk("queue_drained", expq.size(), 0);
    chk("sat_out", {30'h0, sat_out}, {30'h0, msat});
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    expq.delete();
    model_reset();
    #3;
    chk("rst_dac0", {16'h0, DAC0_out}, 32'h0);
    chk("rst_dac1", {16'h0, DAC1_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_rdata", {16'h0, cmd_data_out}, 32'h0);
    chk("rst_sat", {30'h0, sat_out}, 32'h0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  // Monitor: every presented sample must match the oldest expectation.
  always @(negedge clk_in) begin
    if (!rst_in && valid_out) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got %h/%h expected none",
                 DAC0_out, DAC1_out);
      end else begin
        chk("dac_pair", {DAC0_out, DAC1_out}, expq.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] r16;
    cmd_trig_in = 0; cmd_addr_in = 0; cmd_data_in = 0;
    valid_in = 0; data0_in = 0; data1_in = 0;
    rst_in = 1'b0;
    model_reset();
    @(posedge clk_in); #1;
    do_reset();

    rd(8'h02, "rd_max0_rst");
    rd(8'h06, "rd_slew_rst");
    rd(8'h03, "rd_min0_rst");
    rd(8'h09, "rd_unmapped");

    wr(8'h00, 16'h7000);
    smp(16'h2000, 16'h0000);
    drain();
    rd(8'h08, "rd_status_set");
    wr(8'h08, 16'h1234);
    chk("sat_cleared", {30'h0, sat_out}, 32'h0);
    wr(8'h00, 16'h0000);

    wr(8'h04, 16'h1000);
    wr(8'h05, 16'hf000);
    smp(16'h0, 16'h3000);
    smp(16'h0, 16'h8000);
    smp(16'h0, 16'h0123);
    drain();
    wr(8'h08, 16'h0);
    wr(8'h04, 16'h7fff);
    wr(8'h05, 16'h8000);

    wr(8'h06, 16'h0100);
    smp(16'h0, 16'h0);
    for (int k = 0; k < 7; k++) smp(16'h0450, 16'h0);
    drain();

    wr(8'h06, 16'h0000);
    smp(16'h0080, 16'h0);
    idle(4);
    wr(8'h06, 16'h0010);
    wr(8'h07, 16'h0001);
    for (int k = 0; k < 9; k++) smp(16'h0080, 16'h0);
    idle(4);
    wr(8'h07, 16'h0000);
    for (int k = 0; k < 9; k++) smp(16'h0080, 16'h0);
    drain();
    rd(8'h07, "rd_ctrl");

    for (int ph = 0; ph < 30; ph++) begin
      for (int i = 0; i < 8; i++) begin
        r16 = $urandom();
        if (i < 2 && $urandom_range(1)) r16 = $urandom_range(16'h0fff);
        if (i == 6) begin
          case ($urandom_range(2))
            0: r16 = 16'h0;
            1: r16 = $urandom_range(16'h0200, 16'h1);
            default: r16 = $urandom();
          endcase
        end
        if (i == 7) r16 = {14'h0, 2'($urandom_range(3))};
        wr(i[7:0], r16);
      end
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(1))
          smp(16'($urandom()), 16'($urandom()));
        else
          idle(1);
      end
      drain();
      rd(8'($urandom_range(8)), "rd_rand");
      rd(8'h08, "rd_status_rand");
      if ($urandom_range(1)) begin
        wr(8'h08, 16'hffff);
        chk("sat_clr_rand", {30'h0, sat_out}, 32'h0);
      end
    end

    wr(8'h07, 16'h0);
    wr(8'h00, 16'h0);
    wr(8'h01, 16'h0);
    wr(8'h02, 16'h7fff); wr(8'h03, 16'h8000);
    wr(8'h04, 16'h7fff); wr(8'h05, 16'h8000);
    wr(8'h06, 16'h0);
    smp(16'h0100, 16'h0200);
    step(1'b1, 16'h2200, 16'h0300, 1'b1, 16'h0100, 16'h0100);
    smp(16'h0100, 16'h0100);
    drain();

    wr(8'h06, 16'h0008);
    wr(8'h07, 16'h0003);
    smp(16'h0, 16'h0);
    smp(16'h0, 16'h0);
    smp(16'h0, 16'h0);
    do_reset();
    rd(8'h06, "rd_slew_after_rst");
    rd(8'h00, "rd_ofs0_after_rst");
    smp(16'h0040, 16'hffc0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
